// File: rtl/usb_fs_tx_framer.sv
// USB full-speed transmit framer: SYNC, PID, optional payload with CRC16, EOP.
// Bits are bit-stuffed and NRZI-encoded onto registered dp/dn levels.
module usb_fs_tx_framer (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_strobe,
  input  logic       pkt_start,
  input  logic [3:0] pid,
  input  logic       data_avail,
  output logic       data_get,
  input  logic [7:0] data,
  output logic       pkt_end,
  output logic       oe,
  output logic       dp,
  output logic       dn
);

  typedef enum logic [2:0] {StIdle, StSync, StPid, StData, StCrc, StEop} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  ones_q, ones_d;
  logic [15:0] crc_q, crc_d;
  logic [3:0]  pid_q, pid_d;
  logic        oe_q, oe_d;
  logic        dp_q, dp_d;
  logic        dn_q, dn_d;

  logic        stuff;
  logic        tx_bit;
  logic        tx_valid;
  logic        crc_en;
  logic        get_raw;
  logic        end_raw;

  // Next-state logic: one bit time is emitted per bit_strobe while a packet is active.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    ones_d   = ones_q;
    crc_d    = crc_q;
    pid_d    = pid_q;
    oe_d     = oe_q;
    dp_d     = dp_q;
    dn_d     = dn_q;
    tx_bit   = 1'b0;
    tx_valid = 1'b0;
    crc_en   = 1'b0;
    get_raw  = 1'b0;
    end_raw  = 1'b0;
    // A pending stuff bit also precedes EOP when the final field bit completed a run of six.
    stuff = (ones_q == 3'd6) &&
            ((state_q == StPid) || (state_q == StData) || (state_q == StCrc) ||
             ((state_q == StEop) && (cnt_q == 4'd0)));

    unique case (state_q)
      StIdle: begin
        if (pkt_start) begin
          pid_d   = pid;
          crc_d   = 16'hFFFF;
          ones_d  = 3'd0;
          cnt_d   = 4'd0;
          state_d = StSync;
        end
      end
      StSync: begin
        if (bit_strobe) begin
          tx_valid = 1'b1;
          tx_bit   = (cnt_q == 4'd7);
          cnt_d    = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = 4'd0;
            shift_d = {~pid_q, pid_q};
            state_d = StPid;
          end
        end
      end
      StPid: begin
        if (bit_strobe) begin
          tx_valid = 1'b1;
          if (!stuff) begin
            tx_bit  = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d   = 4'd0;
              state_d = (pid_q[1:0] == 2'b11) ? StData : StEop;
            end
          end
        end
      end
      StData: begin
        if (bit_strobe) begin
          tx_valid = 1'b1;
          if (!stuff) begin
            if (cnt_q == 4'd0) begin
              // Byte boundary: either start the next byte or go straight into the CRC field
              // so no idle bit time is inserted.
              cnt_d = 4'd1;
              if (data_avail) begin
                get_raw = 1'b1;
                tx_bit  = data[0];
                shift_d = {1'b0, data[7:1]};
                crc_en  = 1'b1;
              end else begin
                tx_bit  = ~crc_q[0];
                state_d = StCrc;
              end
            end else begin
              tx_bit  = shift_q[0];
              shift_d = shift_q >> 1;
              crc_en  = 1'b1;
              cnt_d   = (cnt_q == 4'd7) ? 4'd0 : cnt_q + 4'd1;
            end
          end
        end
      end
      StCrc: begin
        if (bit_strobe) begin
          tx_valid = 1'b1;
          if (!stuff) begin
            tx_bit = ~crc_q[cnt_q];
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              cnt_d   = 4'd0;
              state_d = StEop;
            end
          end
        end
      end
      StEop: begin
        if (bit_strobe) begin
          if (stuff) begin
            tx_valid = 1'b1;
          end else if (cnt_q < 4'd2) begin
            dp_d  = 1'b0;
            dn_d  = 1'b0;
            cnt_d = cnt_q + 4'd1;
          end else if (cnt_q == 4'd2) begin
            dp_d  = 1'b1;
            dn_d  = 1'b0;
            cnt_d = 4'd3;
          end else begin
            oe_d    = 1'b0;
            dp_d    = 1'b1;
            dn_d    = 1'b0;
            cnt_d   = 4'd0;
            end_raw = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Shared bit path: ones counting and NRZI (0 toggles J/K, 1 holds).
    if (tx_valid) begin
      oe_d   = 1'b1;
      ones_d = tx_bit ? ones_q + 3'd1 : 3'd0;
      if (!tx_bit) begin
        dp_d = ~dp_q;
        dn_d = ~dn_q;
      end
    end

    // Reflected CRC16 (poly 0x8005) over payload bits only.
    if (crc_en) begin
      crc_d = {1'b0, crc_q[15:1]} ^ (((crc_q[0] ^ tx_bit) == 1'b1) ? 16'hA001 : 16'h0000);
    end

    data_get = get_raw & ~reset;
    pkt_end  = end_raw & ~reset;
  end

  // State register with synchronous reset to an idle J line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      shift_q <= 8'd0;
      ones_q  <= 3'd0;
      crc_q   <= 16'hFFFF;
      pid_q   <= 4'd0;
      oe_q    <= 1'b0;
      dp_q    <= 1'b1;
      dn_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ones_q  <= ones_d;
      crc_q   <= crc_d;
      pid_q   <= pid_d;
      oe_q    <= oe_d;
      dp_q    <= dp_d;
      dn_q    <= dn_d;
    end
  end

  assign oe = oe_q;
  assign dp = dp_q;
  assign dn = dn_q;

endmodule
